serial_mod_detector: RTL and testbench

//   Multi-channel serial divisibility detector. Each channel receives a bit

---
 rtl/serial_mod_detector_if.sv | 28 ++
 rtl/serial_mod_detector.sv | 105 ++++++++++
 tb/tb_serial_mod_detector.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_mod_detector_if.sv
// Bus bundle for serial_mod_detector: per-channel serial inputs plus
// per-channel status outputs.
interface serial_mod_detector_if #(
    parameter int DIVISOR = 3,
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16
);
    localparam int REM_W = $clog2(DIVISOR);

    logic [NUM_CH-1:0]       din_valid;
    logic [NUM_CH-1:0]       din;
    logic [NUM_CH-1:0]       clear;
    logic [NUM_CH-1:0]       lsb_first;
    logic [NUM_CH-1:0]       dout;
    logic [NUM_CH-1:0]       active;
    logic [NUM_CH*REM_W-1:0] rem;
    logic [NUM_CH*CNT_W-1:0] bit_cnt;

    modport master (
        output din_valid, din, clear, lsb_first,
        input  dout, active, rem, bit_cnt
    );

    modport slave (
        input  din_valid, din, clear, lsb_first,
        output dout, active, rem, bit_cnt
    );
endinterface

// File: rtl/serial_mod_detector.sv
// Multi-channel serial divisibility detector. Each channel folds its incoming
// bit stream into a running remainder modulo DIVISOR and flags divisibility.
//
// state  | meaning
// -------+-------------------------------------------------------------
// EMPTY  | no bit of the current word accepted; outputs at reset values
// ACTIVE | at least one bit accepted; rem/pow/bit_cnt track the word
module serial_mod_detector #(
    parameter int DIVISOR = 3,
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    serial_mod_detector_if.slave  bus
);
    localparam int REM_W = $clog2(DIVISOR);

    if (DIVISOR < 2) begin : g_bad_divisor
        $error("serial_mod_detector: DIVISOR must be >= 2");
    end
    if (NUM_CH < 1) begin : g_bad_num_ch
        $error("serial_mod_detector: NUM_CH must be >= 1");
    end

    // DIVISOR fits in REM_W+1 bits, so every intermediate below does too.
    localparam logic [REM_W:0]   DIV_X = (REM_W+1)'(DIVISOR);
    localparam logic [REM_W-1:0] ONE   = REM_W'(1);
    localparam logic [REM_W-1:0] POW2  = REM_W'(2 % DIVISOR);

    typedef enum logic {EMPTY = 1'b0, ACTIVE = 1'b1} state_t;

    state_t           state_q  [NUM_CH];
    logic [REM_W-1:0] rem_q    [NUM_CH];
    logic [REM_W-1:0] pow_q    [NUM_CH];
    logic [CNT_W-1:0] cnt_q    [NUM_CH];
    logic             mode_q   [NUM_CH];
    logic             dout_q   [NUM_CH];
    logic [REM_W-1:0] rem_step [NUM_CH];
    logic [REM_W-1:0] pow_step [NUM_CH];

    // Inputs are always below 2*DIVISOR, so one conditional subtract suffices.
    function automatic logic [REM_W-1:0] reduce(input logic [REM_W:0] s);
        logic [REM_W:0] diff;
        diff = s - DIV_X;
        return (s >= DIV_X) ? diff[REM_W-1:0] : s[REM_W-1:0];
    endfunction

    // Next remainder/power for a bit accepted while ACTIVE.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (mode_q[i]) begin
                rem_step[i] = reduce({1'b0, rem_q[i]} +
                                     (bus.din[i] ? {1'b0, pow_q[i]} : '0));
                pow_step[i] = reduce({pow_q[i], 1'b0});
            end else begin
                rem_step[i] = reduce({rem_q[i], bus.din[i]});
                pow_step[i] = pow_q[i];
            end
        end
    end

    // Per-channel EMPTY/ACTIVE FSM with registered status outputs.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (!resetn) begin
                state_q[i] <= EMPTY;
                rem_q[i]   <= '0;
                pow_q[i]   <= ONE;
                cnt_q[i]   <= '0;
                mode_q[i]  <= 1'b0;
                dout_q[i]  <= 1'b0;
            end else if (bus.din_valid[i] && (state_q[i] == EMPTY || bus.clear[i])) begin
                // First bit of a word; a clear in the same cycle drops the old word.
                state_q[i] <= ACTIVE;
                rem_q[i]   <= REM_W'(bus.din[i]);
                pow_q[i]   <= POW2;
                cnt_q[i]   <= CNT_W'(1);
                mode_q[i]  <= bus.lsb_first[i];
                dout_q[i]  <= ~bus.din[i];
            end else if (bus.clear[i]) begin
                state_q[i] <= EMPTY;
                rem_q[i]   <= '0;
                pow_q[i]   <= ONE;
                cnt_q[i]   <= '0;
                mode_q[i]  <= 1'b0;
                dout_q[i]  <= 1'b0;
            end else if (bus.din_valid[i]) begin
                rem_q[i]  <= rem_step[i];
                pow_q[i]  <= pow_step[i];
                dout_q[i] <= (rem_step[i] == '0);
                if (!(&cnt_q[i])) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign bus.dout[g]                    = dout_q[g];
        assign bus.active[g]                  = (state_q[g] == ACTIVE);
        assign bus.rem[g*REM_W +: REM_W]      = rem_q[g];
        assign bus.bit_cnt[g*CNT_W +: CNT_W]  = cnt_q[g];
    end
endmodule

// File: tb/tb_serial_mod_detector.sv
// Bench for serial_mod_detector. Seven lanes over four DUT builds:
// lanes 0-3 D=3 (4 ch), lane 4 D=5, lane 5 D=4, lane 6 D=3 with CNT_W=3.
// The reference keeps each word's true integer value and reduces it with %.
module tb_serial_mod_detector;
    localparam int NL = 7;

    logic clk = 1'b0;
    logic resetn;
    logic [NL-1:0] dv, d, clr, lsb;

    int ldiv [NL] = '{3, 3, 3, 3, 5, 4, 3};
    int lcmax[NL] = '{65535, 65535, 65535, 65535, 65535, 65535, 7};

    int nvec = 0;
    int nerr = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    serial_mod_detector_if #(.DIVISOR(3), .NUM_CH(4), .CNT_W(16)) if_a ();
    serial_mod_detector_if #(.DIVISOR(5), .NUM_CH(1), .CNT_W(16)) if_b ();
    serial_mod_detector_if #(.DIVISOR(4), .NUM_CH(1), .CNT_W(16)) if_c ();
    serial_mod_detector_if #(.DIVISOR(3), .NUM_CH(1), .CNT_W(3))  if_d ();

    serial_mod_detector #(.DIVISOR(3), .NUM_CH(4), .CNT_W(16)) dut_a (.clk(clk), .resetn(resetn), .bus(if_a.slave));
    serial_mod_detector #(.DIVISOR(5), .NUM_CH(1), .CNT_W(16)) dut_b (.clk(clk), .resetn(resetn), .bus(if_b.slave));
    serial_mod_detector #(.DIVISOR(4), .NUM_CH(1), .CNT_W(16)) dut_c (.clk(clk), .resetn(resetn), .bus(if_c.slave));
    serial_mod_detector #(.DIVISOR(3), .NUM_CH(1), .CNT_W(3))  dut_d (.clk(clk), .resetn(resetn), .bus(if_d.slave));

    assign if_a.din_valid = dv[3:0];  assign if_a.din = d[3:0];
    assign if_a.clear     = clr[3:0]; assign if_a.lsb_first = lsb[3:0];
    assign if_b.din_valid = dv[4];    assign if_b.din = d[4];
    assign if_b.clear     = clr[4];   assign if_b.lsb_first = lsb[4];
    assign if_c.din_valid = dv[5];    assign if_c.din = d[5];
    assign if_c.clear     = clr[5];   assign if_c.lsb_first = lsb[5];
    assign if_d.din_valid = dv[6];    assign if_d.din = d[6];
    assign if_d.clear     = clr[6];   assign if_d.lsb_first = lsb[6];

    logic [NL-1:0] o_act, o_dout;
    int o_rem[NL];
    int o_cnt[NL];

    // Flatten all DUT outputs into per-lane views.
    always_comb begin
        for (int l = 0; l < 4; l++) begin
            o_act[l]  = if_a.active[l];
            o_dout[l] = if_a.dout[l];
            o_rem[l]  = int'(if_a.rem[l*2 +: 2]);
            o_cnt[l]  = int'(if_a.bit_cnt[l*16 +: 16]);
        end
        o_act[4] = if_b.active[0]; o_dout[4] = if_b.dout[0];
        o_rem[4] = int'(if_b.rem); o_cnt[4]  = int'(if_b.bit_cnt);
        o_act[5] = if_c.active[0]; o_dout[5] = if_c.dout[0];
        o_rem[5] = int'(if_c.rem); o_cnt[5]  = int'(if_c.bit_cnt);
        o_act[6] = if_d.active[0]; o_dout[6] = if_d.dout[0];
        o_rem[6] = int'(if_d.rem); o_cnt[6]  = int'(if_d.bit_cnt);
    end

    // Reference: the word as an integer plus its length and order.
    longint unsigned mval[NL];
    int              mnb[NL];
    logic [NL-1:0]   mact, mlsb;

    always @(posedge clk) begin
        for (int l = 0; l < NL; l++) begin
            if (!resetn) begin
                mact[l] = 1'b0; mlsb[l] = 1'b0; mval[l] = 0; mnb[l] = 0;
            end else if (dv[l] && (!mact[l] || clr[l])) begin
                mact[l] = 1'b1; mlsb[l] = lsb[l]; mval[l] = longint'(d[l]); mnb[l] = 1;
            end else if (clr[l]) begin
                mact[l] = 1'b0; mlsb[l] = 1'b0; mval[l] = 0; mnb[l] = 0;
            end else if (dv[l]) begin
                if (mlsb[l]) mval[l] = mval[l] + (longint'(d[l]) << mnb[l]);
                else         mval[l] = mval[l] * 2 + longint'(d[l]);
                mnb[l] = mnb[l] + 1;
            end
        end
    end

    function automatic int exp_rem(int l);
        return int'(mval[l] % longint'(ldiv[l]));
    endfunction

    function automatic int exp_cnt(int l);
        return (mnb[l] > lcmax[l]) ? lcmax[l] : mnb[l];
    endfunction

    // Every cycle, every lane: DUT against the reference.
    always @(negedge clk) begin
        if (started) begin
            for (int l = 0; l < NL; l++) begin
                nvec++;
                if (o_act[l] !== mact[l] || o_rem[l] != exp_rem(l) ||
                    o_dout[l] !== (mact[l] && exp_rem(l) == 0) || o_cnt[l] != exp_cnt(l)) begin
                    nerr++;
                    $display("FAIL cycle lane%0d t=%0t: got act=%0b rem=%0d dout=%0b cnt=%0d, want act=%0b rem=%0d dout=%0b cnt=%0d",
                             l, $time, o_act[l], o_rem[l], o_dout[l], o_cnt[l],
                             mact[l], exp_rem(l), mact[l] && exp_rem(l) == 0, exp_cnt(l));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Hand-computed expectation checked against both the DUT and the reference.
    task automatic lit(string nm, int l, bit ea, int er, bit ed, int ec);
        nvec++;
        if (o_act[l] !== ea || o_rem[l] != er || o_dout[l] !== ed || o_cnt[l] != ec) begin
            nerr++;
            $display("FAIL %s lane%0d: got act=%0b rem=%0d dout=%0b cnt=%0d, want act=%0b rem=%0d dout=%0b cnt=%0d",
                     nm, l, o_act[l], o_rem[l], o_dout[l], o_cnt[l], ea, er, ed, ec);
        end
        nvec++;
        if (mact[l] !== ea || exp_rem(l) != er || exp_cnt(l) != ec) begin
            nerr++;
            $display("FAIL %s_model lane%0d: got act=%0b rem=%0d cnt=%0d, want act=%0b rem=%0d cnt=%0d",
                     nm, l, mact[l], exp_rem(l), exp_cnt(l), ea, er, ec);
        end
    endtask

    task automatic feed(int l, bit lsb_v, bit b);
        dv[l] = 1'b1; d[l] = b; lsb[l] = lsb_v;
        tick();
        dv[l] = 1'b0; d[l] = 1'b0;
    endtask

    initial begin
        bit b1[3] = '{1, 1, 0};  int r1[3] = '{1, 0, 0};    bit o1[3] = '{0, 1, 1};
        bit b2[4] = '{1, 0, 1, 1}; int r2[4] = '{1, 1, 2, 1};
        bit b3[4] = '{1, 0, 1, 0}; int r3[4] = '{1, 2, 0, 0}; bit o3[4] = '{0, 0, 1, 1};
        int r5[5] = '{1, 3, 3, 3, 3};
        bit b6[9] = '{1, 0, 1, 1, 0, 0, 1, 1, 1};

        resetn = 1'b0; dv = '0; d = '0; clr = '0; lsb = '0;
        @(negedge clk);
        tick();
        started = 1'b1;
        for (int l = 0; l < NL; l++) lit("reset", l, 0, 0, 0, 0);
        resetn = 1'b1;
        tick();

        // D=3 MSB 1,1,0 -> value 6
        for (int k = 0; k < 3; k++) begin
            feed(0, 1'b0, b1[k]);
            lit("msb6", 0, 1, r1[k], o1[k], k + 1);
        end

        // D=3 LSB 1,0,1,1 -> value 13; lsb_first dropped after the first bit
        for (int k = 0; k < 4; k++) begin
            feed(1, k == 0, b2[k]);
            lit("lsb13", 1, 1, r2[k], 1'b0, k + 1);
        end

        // D=5 MSB 1,0,1,0 -> value 10
        for (int k = 0; k < 4; k++) begin
            feed(4, 1'b0, b3[k]);
            lit("d5_msb10", 4, 1, r3[k], o3[k], k + 1);
        end

        // D=4 LSB 1,1,1,1,1 -> pow reaches 0 after two bits, rem stays 3
        for (int k = 0; k < 5; k++) begin
            feed(5, 1'b1, 1'b1);
            lit("d4_lsb", 5, 1, r5[k], 1'b0, k + 1);
        end

        // Clear with a bit in the same cycle starts a new word
        feed(2, 1'b0, 1'b1);
        feed(2, 1'b0, 1'b0);
        lit("pre_clear", 2, 1, 2, 0, 2);
        clr[2] = 1'b1; dv[2] = 1'b1; d[2] = 1'b0;
        tick();
        clr[2] = 1'b0; dv[2] = 1'b0;
        lit("clear_bit", 2, 1, 0, 1, 1);
        clr[2] = 1'b1;
        tick();
        clr[2] = 1'b0;
        lit("clear_only", 2, 0, 0, 0, 0);

        // Idle cycles hold state
        tick(); tick();
        lit("hold", 0, 1, 0, 1, 3);

        // Reset mid-word overrides valid bits
        resetn = 1'b0; dv = '1; d = '1;
        tick();
        resetn = 1'b1; dv = '0; d = '0;
        for (int l = 0; l < NL; l++) lit("reset_mid", l, 0, 0, 0, 0);

        // CNT_W=3: 9 bits 101100111 = 359, 359 mod 3 = 2, count saturates at 7
        for (int k = 0; k < 9; k++) feed(6, 1'b0, b6[k]);
        lit("cnt_sat", 6, 1, 2, 0, 7);

        // All lanes at once: random gaps, clears, and lsb_first toggling every cycle
        for (int c = 0; c < 300; c++) begin
            for (int l = 0; l < NL; l++) begin
                dv[l]  = ($urandom_range(0, 2) != 0);
                d[l]   = 1'($urandom_range(0, 1));
                lsb[l] = 1'($urandom_range(0, 1));
                clr[l] = ($urandom_range(0, 11) == 0) || (mnb[l] >= 40);
            end
            tick();
        end
        dv = '0; clr = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
